mmu_ctrl: RTL and testbench
===========================

# mmu_ctrl

Sequencer for the 2x2 weight-stationary systolic MMU. It accepts one 2x2 activation matrix A and one 2x2 weight matrix W per job, drives the MMU weight-load, skewed-feed and drain cycles, and de-skews the two MMU column outputs into a registered 2x2 result matrix C = A·W (mod 2^DATA_W). It sits between the host/unified-buffer side and the `mmu` instance and owns every MMU control and data input.

## Interface
- DATA_W, 8, width of activations, weights, partial sums and results. Only 8 is verified.

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  job request; accepted only in IDLE
- a00, a01, a10, a11  in  DATA_W each  A[row][k]; latched on accepted start
- w00, w01, w10, w11  in  DATA_W each  W[k][col]; latched on accepted start
- busy  out  1  high from the cycle after acceptance through the DONE cycle
- done  out  1  one-cycle pulse; C is valid in that cycle
- c_valid  out  1  high from DONE until the next start is accepted
- c00, c01, c10, c11  out  DATA_W each  result registers C[row][col]
- mmu_load_weight  out  1  to MMU load_weight
- mmu_valid  out  1  to MMU valid
- mmu_a_in1, mmu_a_in2  out  DATA_W  to MMU a_in1 / a_in2
- mmu_weight1..4  out  DATA_W  to MMU weight1..weight4, driven from latched w00, w10, w01, w11 respectively
- mmu_acc_out1, mmu_acc_out2  in  DATA_W  from MMU acc_out1 / acc_out2

## Operation
- MMU contract: load_weight=1 captures the weights into the PEs. When valid=1, each PE registers a_out<=a_in and acc_out<=acc_in+a_in*weight, truncated to DATA_W. When valid=0, each PE holds its state.
- Column mapping: acc_out1 = a_in1·W[0][0] + a_in2·W[1][0]; acc_out2 = a_in1·W[0][1] + a_in2·W[1][1].
- FSM states: IDLE -> LOAD -> FEED (4 cycles, counter f=0..3) -> DRAIN -> DONE -> IDLE.
- IDLE: all MMU control outputs are 0. If start=1, latch A and W, clear c_valid, and go to LOAD.
- LOAD (1 cycle): mmu_load_weight=1, mmu_valid=0.
- FEED: mmu_valid=1 and inputs are skewed by one cycle per row.
  - f=0: a_in1=a00, a_in2=0
  - f=1: a_in1=a10, a_in2=a01
  - f=2: a_in1=0, a_in2=a11
  - f=3: a_in1=0, a_in2=0
- Captures from the MMU:
  - f=2: c00 <= acc_out1
  - f=3: c10 <= acc_out1, c01 <= acc_out2
  - DRAIN: c11 <= acc_out2; mmu_valid=0 and the MMU holds.
- DONE: done=1 and c_valid<=1. start is ignored in this state. Return to IDLE.
- mmu_a_in1/2 are 0 in every state or cycle not listed above. mmu_weight* always reflect the latched weights.
- Stale PE contents from a previous job only affect MMU outputs that are never captured. No MMU clear is required between jobs.
- Arithmetic is mod 2^DATA_W with no saturation and no overflow flag.

## Timing
- Reset values (asserted asynchronously while reset=0):
  - FSM=IDLE, counter=0
  - busy, done, c_valid = 0
  - c00..c11 = 0, latched A/W = 0
  - all mmu_* outputs = 0
- Latency: start sampled in cycle S (IDLE).
  - LOAD in S+1, FEED in S+2..S+5, DRAIN in S+6.
  - DONE and done=1 in S+7; IDLE in S+8.
  - A new start is accepted at S+8 at the earliest, giving 8-cycle job throughput.
- busy=1 for S+1..S+7 inclusive.
- start while busy: ignored and not queued. Inputs changing after acceptance have no effect.
- c00..c11 may change during S+4..S+6. They are stable from S+7 and held until overwritten by the next job.
- c_valid drops in the cycle after the next start is accepted.
- Reset asserted mid-job: the job is abandoned, the FSM returns to IDLE, and the next start after release begins a fresh job.

## Test plan
- Reset then idle: while reset=0 and for 5 cycles after, all outputs are 0 and busy=0.
- Basic job: A=[[1,2],[3,4]], W=[[5,6],[7,8]], start at S -> mmu_load_weight=1 only at S+1, mmu_valid=1 at S+2..S+5, done at S+7 with C=[[19,22],[43,50]] and c_valid=1.
- Wrap: A=[[16,16],[16,16]], W=[[16,16],[16,16]] -> C all 0 (512 mod 256). A=[[255,1],[0,0]], W=[[2,0],[1,0]] -> c00=255.
- Back-to-back: second start held high from S+1 to S+8 -> accepted only at S+8. The second done is at S+15 with the second job's results; the first C is held until S+10.
- Ignore start: pulse start at S+3 with different A/W -> the result matches the original job and no extra done is produced.
- Mid-job reset: assert reset at S+4 for 2 cycles -> immediate IDLE with all outputs 0. A new job then completes with correct C and no done from the aborted job.

Source files
------------

// File: rtl/mmu_ctrl_if.sv
// Host and MMU-side signal bundle for the 2x2 systolic MMU sequencer.
// slave is the controller's view; master is the host/MMU-side view.
interface mmu_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] a00, a01, a10, a11;
  logic [DATA_W-1:0] w00, w01, w10, w11;
  logic              busy;
  logic              done;
  logic              c_valid;
  logic [DATA_W-1:0] c00, c01, c10, c11;
  logic              mmu_load_weight;
  logic              mmu_valid;
  logic [DATA_W-1:0] mmu_a_in1, mmu_a_in2;
  logic [DATA_W-1:0] mmu_weight1, mmu_weight2, mmu_weight3, mmu_weight4;
  logic [DATA_W-1:0] mmu_acc_out1, mmu_acc_out2;

  modport slave (
    input  start, a00, a01, a10, a11, w00, w01, w10, w11, mmu_acc_out1, mmu_acc_out2,
    output busy, done, c_valid, c00, c01, c10, c11, mmu_load_weight, mmu_valid,
           mmu_a_in1, mmu_a_in2, mmu_weight1, mmu_weight2, mmu_weight3, mmu_weight4
  );

  modport master (
    output start, a00, a01, a10, a11, w00, w01, w10, w11, mmu_acc_out1, mmu_acc_out2,
    input  busy, done, c_valid, c00, c01, c10, c11, mmu_load_weight, mmu_valid,
           mmu_a_in1, mmu_a_in2, mmu_weight1, mmu_weight2, mmu_weight3, mmu_weight4
  );
endinterface

// File: rtl/mmu_ctrl.sv
// Sequencer for a 2x2 weight-stationary systolic MMU: loads W, feeds skewed A rows,
// and de-skews the two column outputs into a registered C = A*W (mod 2^DATA_W).
module mmu_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic      clk,
  input  logic      reset,
  mmu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StFeed, StDrain, StDone} state_e;

  state_e            state_q;
  logic [1:0]        feed_cnt_q;
  logic [DATA_W-1:0] a00_q, a01_q, a10_q, a11_q;
  logic [DATA_W-1:0] w00_q, w01_q, w10_q, w11_q;

  // PE order is column-major: weight1/2 feed column 0, weight3/4 feed column 1.
  assign bus.mmu_weight1 = w00_q;
  assign bus.mmu_weight2 = w10_q;
  assign bus.mmu_weight3 = w01_q;
  assign bus.mmu_weight4 = w11_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= StIdle;
      feed_cnt_q          <= 2'd0;
      {a00_q, a01_q, a10_q, a11_q} <= '0;
      {w00_q, w01_q, w10_q, w11_q} <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.c_valid         <= 1'b0;
      bus.c00             <= '0;
      bus.c01             <= '0;
      bus.c10             <= '0;
      bus.c11             <= '0;
      bus.mmu_load_weight <= 1'b0;
      bus.mmu_valid       <= 1'b0;
      bus.mmu_a_in1       <= '0;
      bus.mmu_a_in2       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            a00_q               <= bus.a00;
            a01_q               <= bus.a01;
            a10_q               <= bus.a10;
            a11_q               <= bus.a11;
            w00_q               <= bus.w00;
            w01_q               <= bus.w01;
            w10_q               <= bus.w10;
            w11_q               <= bus.w11;
            bus.c_valid         <= 1'b0;
            bus.busy            <= 1'b1;
            bus.mmu_load_weight <= 1'b1;
            state_q             <= StLoad;
          end
        end
        StLoad: begin
          bus.mmu_load_weight <= 1'b0;
          bus.mmu_valid       <= 1'b1;
          bus.mmu_a_in1       <= a00_q;
          bus.mmu_a_in2       <= '0;
          feed_cnt_q          <= 2'd0;
          state_q             <= StFeed;
        end
        StFeed: begin
          feed_cnt_q <= feed_cnt_q + 2'd1;
          // Outputs set here apply to the next feed step; captures sample this one.
          unique case (feed_cnt_q)
            2'd0: begin
              bus.mmu_a_in1 <= a10_q;
              bus.mmu_a_in2 <= a01_q;
            end
            2'd1: begin
              bus.mmu_a_in1 <= '0;
              bus.mmu_a_in2 <= a11_q;
            end
            2'd2: begin
              bus.mmu_a_in1 <= '0;
              bus.mmu_a_in2 <= '0;
              bus.c00       <= bus.mmu_acc_out1;
            end
            default: begin
              bus.c10       <= bus.mmu_acc_out1;
              bus.c01       <= bus.mmu_acc_out2;
              bus.mmu_valid <= 1'b0;
              state_q       <= StDrain;
            end
          endcase
        end
        StDrain: begin
          bus.c11     <= bus.mmu_acc_out2;
          bus.done    <= 1'b1;
          bus.c_valid <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_ctrl.sv
// Directed bench for mmu_ctrl with a behavioural 2x2 systolic MMU and a result scoreboard.
module tb_mmu_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  int   n_done;
  logic [31:0] sb[$];

  mmu_ctrl_if #(.DATA_W(8)) bus ();

  mmu_ctrl #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MMU: index 0=PE[0][0], 1=PE[1][0], 2=PE[0][1], 3=PE[1][1].
  logic [7:0] pw [4];
  logic [7:0] pa [4];
  logic [7:0] pacc [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pw[i]   <= '0;
        pa[i]   <= '0;
        pacc[i] <= '0;
      end
    end else begin
      if (bus.mmu_load_weight) begin
        pw[0] <= bus.mmu_weight1;
        pw[1] <= bus.mmu_weight2;
        pw[2] <= bus.mmu_weight3;
        pw[3] <= bus.mmu_weight4;
      end
      if (bus.mmu_valid) begin
        pa[0]   <= bus.mmu_a_in1;
        pacc[0] <= 8'(bus.mmu_a_in1 * pw[0]);
        pa[1]   <= bus.mmu_a_in2;
        pacc[1] <= 8'(pacc[0] + 8'(bus.mmu_a_in2 * pw[1]));
        pa[2]   <= pa[0];
        pacc[2] <= 8'(pa[0] * pw[2]);
        pa[3]   <= pa[1];
        pacc[3] <= 8'(pacc[2] + 8'(pa[1] * pw[3]));
      end
    end
  end

  assign bus.mmu_acc_out1 = pacc[1];
  assign bus.mmu_acc_out2 = pacc[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Packed as {x00, x01, x10, x11}.
  function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] w);
    logic [15:0] c00, c01, c10, c11;
    c00 = a[31:24] * w[31:24] + a[23:16] * w[15:8];
    c01 = a[31:24] * w[23:16] + a[23:16] * w[7:0];
    c10 = a[15:8] * w[31:24] + a[7:0] * w[15:8];
    c11 = a[15:8] * w[23:16] + a[7:0] * w[7:0];
    return {c00[7:0], c01[7:0], c10[7:0], c11[7:0]};
  endfunction

  task automatic set_inputs(input logic [31:0] a, input logic [31:0] w);
    {bus.a00, bus.a01, bus.a10, bus.a11} = a;
    {bus.w00, bus.w01, bus.w10, bus.w11} = w;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_cvalid"}, 32'(bus.c_valid), 32'd0);
    chk({tag, "_c"}, {bus.c00, bus.c01, bus.c10, bus.c11}, 32'd0);
    chk({tag, "_mmu_ctl"}, 32'({bus.mmu_load_weight, bus.mmu_valid}), 32'd0);
    chk({tag, "_mmu_a"}, 32'({bus.mmu_a_in1, bus.mmu_a_in2}), 32'd0);
    chk({tag, "_mmu_w"}, {bus.mmu_weight1, bus.mmu_weight2, bus.mmu_weight3, bus.mmu_weight4},
        32'd0);
  endtask

  task automatic do_job(input logic [31:0] a, input logic [31:0] w);
    logic got;
    @(negedge clk);
    set_inputs(a, w);
    bus.start = 1'b1;
    sb.push_back(calc(a, w));
    @(negedge clk);
    bus.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    chk("job_done_seen", 32'(got), 32'd1);
  endtask

  // Scoreboard consumer: every done must match the oldest outstanding job.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_done++;
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("c_matrix", {bus.c00, bus.c01, bus.c10, bus.c11}, sb.pop_front());
        chk("c_valid_at_done", 32'(bus.c_valid), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  exp_ain1 [4] = '{8'd1, 8'd3, 8'd0, 8'd0};
  logic [7:0]  exp_ain2 [4] = '{8'd0, 8'd2, 8'd4, 8'd0};
  logic [31:0] job1_exp;
  int          d0;

  initial begin
    n_checks = 0;
    n_err    = 0;
    n_done   = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    set_inputs(32'h0102_0304, 32'h0506_0708);

    repeat (3) @(negedge clk);
    check_idle("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle("post_reset");
    end

    // Basic job with full timeline: A=[[1,2],[3,4]], W=[[5,6],[7,8]].
    @(negedge clk);
    set_inputs(32'h0102_0304, 32'h0506_0708);
    bus.start = 1'b1;
    sb.push_back({8'd19, 8'd22, 8'd43, 8'd50});
    @(negedge clk);
    bus.start = 1'b0;
    chk("load_s1", 32'(bus.mmu_load_weight), 32'd1);
    chk("valid_s1", 32'(bus.mmu_valid), 32'd0);
    chk("busy_s1", 32'(bus.busy), 32'd1);
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      chk("feed_valid", 32'(bus.mmu_valid), 32'd1);
      chk("feed_load", 32'(bus.mmu_load_weight), 32'd0);
      chk("feed_a_in1", 32'(bus.mmu_a_in1), 32'(exp_ain1[f]));
      chk("feed_a_in2", 32'(bus.mmu_a_in2), 32'(exp_ain2[f]));
    end
    @(negedge clk);
    chk("drain_valid", 32'(bus.mmu_valid), 32'd0);
    chk("drain_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("s7_done", 32'(bus.done), 32'd1);
    chk("s7_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("s8_done", 32'(bus.done), 32'd0);
    chk("s8_busy", 32'(bus.busy), 32'd0);
    chk("s8_cvalid", 32'(bus.c_valid), 32'd1);
    chk("s8_c_held", {bus.c00, bus.c01, bus.c10, bus.c11}, {8'd19, 8'd22, 8'd43, 8'd50});

    // Wraparound.
    do_job(32'h1010_1010, 32'h1010_1010);
    do_job(32'hFF01_0000, 32'h0200_0100);

    // Back-to-back: start held high S..S+8, second job accepted at S+8.
    job1_exp = calc(32'h0908_0706, 32'h0102_0304);
    @(negedge clk);
    set_inputs(32'h0908_0706, 32'h0102_0304);
    bus.start = 1'b1;
    sb.push_back(job1_exp);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        set_inputs(32'h0203_0507, 32'h0B0D_1113);
        sb.push_back(calc(32'h0203_0507, 32'h0B0D_1113));
      end
      chk("b2b_busy", 32'(bus.busy), 32'(i <= 7));
      chk("b2b_done", 32'(bus.done), 32'(i == 7));
    end
    chk("b2b_s8_cvalid", 32'(bus.c_valid), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_s9_cvalid", 32'(bus.c_valid), 32'd0);
    chk("b2b_s9_busy", 32'(bus.busy), 32'd1);
    chk("b2b_s9_c_held", {bus.c00, bus.c01, bus.c10, bus.c11}, job1_exp);
    @(negedge clk);
    chk("b2b_s10_c_held", {bus.c00, bus.c01, bus.c10, bus.c11}, job1_exp);
    for (int i = 11; i <= 15; i++) begin
      @(negedge clk);
      chk("b2b_done2", 32'(bus.done), 32'(i == 15));
    end
    @(negedge clk);

    // Start pulse mid-job with different operands must be ignored.
    d0 = n_done;
    @(negedge clk);
    set_inputs(32'h0304_0506, 32'h0708_090A);
    bus.start = 1'b1;
    sb.push_back(calc(32'h0304_0506, 32'h0708_090A));
    @(negedge clk);
    bus.start = 1'b0;
    set_inputs(32'h6363_6363, 32'h2121_2121);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("ignore_done_count", 32'(n_done - d0), 32'd1);

    // Mid-job reset at S+4 for two cycles.
    d0 = n_done;
    @(negedge clk);
    set_inputs(32'h1122_3344, 32'h0102_0304);
    bus.start = 1'b1;
    sb.push_back(calc(32'h1122_3344, 32'h0102_0304));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_idle("abort_now");
    @(negedge clk);
    check_idle("abort_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("abort_release");
    do_job(32'h0A0B_0C0D, 32'h0201_0302);
    repeat (3) @(negedge clk);
    chk("abort_done_count", 32'(n_done - d0), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
